// File: rtl/mux_sel_decode.sv
// One-hot mux select generator with burst hold and back-to-back bursts.
// Out-of-range indices are dropped and flagged with a one-cycle err pulse.
module mux_sel_decode #(
    parameter int N     = 16,
    parameter int LEN_W = 4,
    localparam int IDX_W = $clog2(N)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [IDX_W-1:0] in_idx,
    input  logic [LEN_W-1:0] in_len,
    output logic             in_ready,
    output logic [N-1:0]     sel,
    output logic             sel_valid,
    output logic             sel_last,
    output logic             err
);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] HOLD = 1'b1;

    logic [0:0]       state;
    logic [LEN_W-1:0] cnt;
    logic             accept;
    logic             in_range;

    // A power-of-two N makes every index legal, so skip the compare.
    generate
        if (N == (1 << IDX_W)) begin : g_full
            assign in_range = 1'b1;
        end else begin : g_part
            localparam logic [IDX_W-1:0] LIMIT = IDX_W'(N);
            assign in_range = in_idx < LIMIT;
        end
    endgenerate

    assign sel_last = (state == HOLD) && (cnt == '0);
    assign in_ready = !rst && ((state == IDLE) || sel_last);
    assign accept   = in_valid && in_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            sel       <= '0;
            sel_valid <= 1'b0;
            err       <= 1'b0;
        end else begin
            err <= 1'b0;
            if (accept) begin
                if (in_range) begin
                    state     <= HOLD;
                    cnt       <= in_len;
                    sel       <= N'(1) << in_idx;
                    sel_valid <= 1'b1;
                end else begin
                    state     <= IDLE;
                    cnt       <= '0;
                    sel       <= '0;
                    sel_valid <= 1'b0;
                    err       <= 1'b1;
                end
            end else if (state == HOLD) begin
                if (cnt != '0) begin
                    cnt <= cnt - 1'b1;
                end else begin
                    state     <= IDLE;
                    sel       <= '0;
                    sel_valid <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_mux_sel_decode.sv
// Bench for mux_sel_decode: N=16 and N=12 instances share stimulus and
// are compared against a beats-remaining reference model.
module tb_mux_sel_decode;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [3:0]  in_idx;
    logic [3:0]  in_len;

    logic        rdy16, sv16, sl16, err16;
    logic [15:0] sel16;
    logic        rdy12, sv12, sl12, err12;
    logic [11:0] sel12;

    int nchk = 0;
    int nbad = 0;

    int rem[2];
    int cur[2];
    bit perr[2];
    int nmax[2] = '{16, 12};

    always #5 clk = ~clk;

    mux_sel_decode #(.N(16), .LEN_W(4)) dut16 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_idx(in_idx),
        .in_len(in_len), .in_ready(rdy16), .sel(sel16),
        .sel_valid(sv16), .sel_last(sl16), .err(err16)
    );

    mux_sel_decode #(.N(12), .LEN_W(4)) dut12 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_idx(in_idx),
        .in_len(in_len), .in_ready(rdy12), .sel(sel12),
        .sel_valid(sv12), .sel_last(sl12), .err(err12)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        nchk++;
        if (got !== exp) begin
            nbad++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step(input bit v, input int idx, input int len,
                        input bit r);
        bit acc;
        rst      = r;
        in_valid = v;
        in_idx   = 4'(idx);
        in_len   = 4'(len);
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            logic [31:0] xs;
            bit xr;
            xs = (rem[k] > 0) ? (32'd1 << cur[k]) : 32'd0;
            xr = !r && (rem[k] <= 1);
            if (k == 0) begin
                chk("sel16", 32'(sel16), xs);
                chk("sel_valid16", 32'(sv16), 32'(rem[k] > 0));
                chk("sel_last16", 32'(sl16), 32'(rem[k] == 1));
                chk("in_ready16", 32'(rdy16), 32'(xr));
                chk("err16", 32'(err16), 32'(perr[k]));
            end else begin
                chk("sel12", 32'(sel12), xs);
                chk("sel_valid12", 32'(sv12), 32'(rem[k] > 0));
                chk("sel_last12", 32'(sl12), 32'(rem[k] == 1));
                chk("in_ready12", 32'(rdy12), 32'(xr));
                chk("err12", 32'(err12), 32'(perr[k]));
            end
            acc = v && xr;
            perr[k] = 1'b0;
            if (r) begin
                rem[k] = 0;
            end else if (acc) begin
                if (idx < nmax[k]) begin
                    rem[k] = len + 1;
                    cur[k] = idx;
                end else begin
                    rem[k]  = 0;
                    perr[k] = 1'b1;
                end
            end else if (rem[k] > 0) begin
                rem[k]--;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) step(1'b0, 0, 0, 1'b0);
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_idx = '0; in_len = '0;
        repeat (2) @(posedge clk);
        #1;
        for (int k = 0; k < 2; k++) begin
            rem[k] = 0; cur[k] = 0; perr[k] = 1'b0;
        end
        // reset state, request ignored while in reset
        step(1'b1, 3, 2, 1'b1);
        step(1'b0, 0, 0, 1'b1);
        // first cycle out of reset, basic burst idx 5 len 3
        step(1'b1, 5, 3, 1'b0);
        idle(5);
        // single beat then back-to-back burst on sel_last
        step(1'b1, 0, 0, 1'b0);
        step(1'b1, 15, 1, 1'b0);
        idle(3);
        // in_valid held high during a burst
        step(1'b1, 3, 4, 1'b0);
        repeat (5) step(1'b1, 7, 2, 1'b0);
        idle(4);
        // reset on 2nd beat of a len 7 burst, then recover
        step(1'b1, 2, 7, 1'b0);
        step(1'b0, 0, 0, 1'b0);
        step(1'b0, 0, 0, 1'b1);
        step(1'b1, 9, 1, 1'b0);
        idle(3);
        // out-of-range on the N=12 instance
        step(1'b1, 13, 0, 1'b0);
        idle(2);
        step(1'b1, 12, 2, 1'b0);
        idle(4);
        // sweep all indices with random length
        for (int i = 0; i < 16; i++) begin
            int l;
            l = $urandom_range(0, 15);
            step(1'b1, i, l, 1'b0);
            idle(l + 1);
        end
        // random traffic with occasional reset
        for (int i = 0; i < 600; i++) begin
            step(($urandom % 3) != 0, $urandom_range(0, 15),
                 ($urandom % 2) ? $urandom_range(0, 15) : $urandom_range(0, 1),
                 ($urandom % 25) == 0);
        end
        idle(3);
        $display("== %0d vectors applied, %0d miscompares ==", nchk, nbad);
        $finish;
    end

endmodule

// File: doc/mux_sel_decode.md
MUX_SEL_DECODE -- requirements
Module: mux_sel_decode

Interface
REQ-001 SHALL have parameter N, default 16: number of switch ports / select lines.
REQ-002 SHALL have parameter LEN_W, default 4: width of the burst-length field.
REQ-003 SHALL have port clk, input, 1 bit: single clock; all state updates on the rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 SHALL have port in_valid, input, 1 bit: request present.
REQ-006 SHALL have port in_idx, input, $clog2(N) bits: binary port index to select.
REQ-007 SHALL have port in_len, input, LEN_W bits: burst beats minus one.
REQ-008 SHALL have port in_ready, output, 1 bit: request can be accepted this cycle.
REQ-009 SHALL have port sel, output, N bits: registered one-hot mux select.
REQ-010 SHALL have port sel_valid, output, 1 bit: sel is driving a burst beat.
REQ-011 SHALL have port sel_last, output, 1 bit: current beat is the final beat of the burst.
REQ-012 SHALL have port err, output, 1 bit: one-cycle pulse flagging an out-of-range index.

Function
REQ-013 SHALL accept a request in any cycle where in_valid=1, in_ready=1 and rst=0; in_idx and in_len SHALL be ignored in all other cycles.
REQ-014 SHALL implement two states, IDLE and HOLD, with a LEN_W-bit down-counter cnt.
REQ-015 SHALL, on accept with in_idx<N: enter HOLD next cycle; sel=1<<in_idx; sel_valid=1; cnt=in_len.
REQ-016 SHALL give 1-cycle latency from accept to the first beat on sel, and hold sel stable for exactly in_len+1 cycles.
REQ-017 SHALL, in HOLD with cnt!=0 and no reset: decrement cnt by 1 per cycle, leaving sel unchanged.
REQ-018 SHALL drive sel_last = (state==HOLD && cnt==0), combinationally from registered state.
REQ-019 SHALL drive in_ready = !rst && (state==IDLE || sel_last), combinationally.
REQ-020 SHALL, on the last beat with a valid accept: load the new sel and cnt with no idle bubble (back-to-back bursts).
REQ-021 SHALL, on the last beat without an accept: return to IDLE next cycle with sel=0 and sel_valid=0.
REQ-022 SHALL, on accept with in_idx>=N (only reachable when N is not a power of 2): drop the request, pulse err=1 for exactly the next cycle, and go to IDLE with sel=0.
REQ-023 SHALL keep sel either exactly one-hot or all-zero, with sel_valid == |sel at all times.
REQ-024 SHALL leave in_len=0 legal, producing a single-beat burst with sel_last=1 on its only beat.
REQ-025 SHALL keep cnt from wrapping, because a decrement never occurs at cnt==0.

Reset
REQ-026 SHALL, at a rising edge with rst=1: set state=IDLE, cnt=0, sel=0, sel_valid=0, err=0.
REQ-027 SHALL hold in_ready=0 while rst=1, so no request is accepted during reset.
REQ-028 SHALL, on rst asserted mid-burst: abort the burst, with sel=0 on the following cycle and no err.
REQ-029 SHALL present in_ready=1 in the first cycle after rst deasserts.

Verification
REQ-030 SHALL cover: N=16, accept in_idx=5, in_len=3 -> sel=16'h0020 for 4 cycles, sel_last on the 4th beat, then sel=0 and in_ready=1.
REQ-031 SHALL cover: in_len=0, idx=0 followed by an accept on sel_last of idx=15, in_len=1 -> sel=0x0001 for 1 cycle, then 0x8000 for 2 cycles, no bubble.
REQ-032 SHALL cover: in_valid held high while in HOLD with cnt!=0 -> no accept, sel unchanged, in_ready=0 until sel_last.
REQ-033 SHALL cover: N=12, accept in_idx=13 -> err=1 for one cycle, sel=0, sel_valid=0, state IDLE.
REQ-034 SHALL cover: rst asserted on the 2nd beat of an in_len=7 burst -> next cycle sel=0 and sel_valid=0; after rst drops, in_ready=1 and a new accept works normally.
REQ-035 SHALL cover: sweep in_idx over 0..N-1 with random in_len -> sel equals 1<<in_idx for exactly in_len+1 cycles each time.
